// File: rtl/gray_fifo_wr_ctrl.sv
// gray_fifo_wr_ctrl: write-side pointer, full/fill and drain control for a Gray-coded CDC FIFO.
// Optional registered almost_full_o when GRAY_FIFO_ALMOST_FULL_EN is defined.
module gray_to_binary #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[W-1:i];
  end
endmodule

module gray_fifo_wr_ctrl #(
  parameter int LOG_DEPTH   = 3,
  parameter int SYNC_STAGES = 2
`ifdef GRAY_FIFO_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH   = (2 ** LOG_DEPTH) - 1
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 wr_en_o,
  output logic [LOG_DEPTH-1:0] wr_addr_o,
  output logic [LOG_DEPTH:0]   wptr_gray_o,
  input  logic [LOG_DEPTH:0]   rptr_gray_async_i,
  output logic [LOG_DEPTH:0]   fill_o,
  input  logic                 flush_req_i,
  output logic                 flush_ack_o
`ifdef GRAY_FIFO_ALMOST_FULL_EN
  ,
  output logic                 almost_full_o
`endif
);
  localparam int PW    = LOG_DEPTH + 1;
  localparam int DEPTH = 2 ** LOG_DEPTH;

  typedef enum logic [1:0] {RUN, DRAIN, ACK} state_e;

  logic [PW-1:0] wptr_bin_q, wptr_bin_d, wptr_gray_q, wptr_gray_d, rptr_bin;
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
  state_e state_q, state_d;
  logic flush_ack_q, flush_ack_d, full;

  gray_to_binary #(.W(PW)) u_g2b (.gray_i(sync_q[SYNC_STAGES-1]), .bin_o(rptr_bin));

  always_comb begin
    fill_o      = wptr_bin_q - rptr_bin;
    full        = fill_o == PW'(DEPTH);
    ready_o     = state_q == RUN && !full;
    wr_en_o     = valid_i && ready_o;
    wr_addr_o   = wptr_bin_q[LOG_DEPTH-1:0];
    wptr_bin_d  = wptr_bin_q + PW'(wr_en_o);
    wptr_gray_d = (wptr_bin_d >> 1) ^ wptr_bin_d;
    sync_d      = {sync_q[SYNC_STAGES-2:0], rptr_gray_async_i};
    state_d     = state_q == RUN   ? (flush_req_i ? DRAIN : RUN) :
                  state_q == DRAIN ? (fill_o == '0 ? ACK : DRAIN) :
                                     (flush_req_i ? DRAIN : RUN);
    flush_ack_d = state_d == ACK;
  end

  assign wptr_gray_o = wptr_gray_q;
  assign flush_ack_o = flush_ack_q;

`ifdef GRAY_FIFO_ALMOST_FULL_EN
  // Next-cycle fill uses the value the last sync stage is about to take.
  logic [PW-1:0] rptr_bin_nxt, fill_nxt;
  logic almost_full_q;
  gray_to_binary #(.W(PW)) u_g2b_nxt (.gray_i(sync_q[SYNC_STAGES-2]), .bin_o(rptr_bin_nxt));
  assign fill_nxt      = wptr_bin_d - rptr_bin_nxt;
  assign almost_full_o = almost_full_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
      sync_q      <= '0;
      state_q     <= RUN;
      flush_ack_q <= 1'b0;
`ifdef GRAY_FIFO_ALMOST_FULL_EN
      almost_full_q <= 1'b0;
`endif
    end else begin
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
      sync_q      <= sync_d;
      state_q     <= state_d;
      flush_ack_q <= flush_ack_d;
`ifdef GRAY_FIFO_ALMOST_FULL_EN
      almost_full_q <= fill_nxt >= PW'(AF_THRESH);
`endif
    end
  end
endmodule
